// File: rtl/sd_req_arbiter_if.sv
// Bus bundle for sd_req_arbiter: two block-device requesters on one side,
// the shared user_io SD host port on the other.
interface sd_req_arbiter_if;
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [31:0] lba0;
    logic [31:0] lba1;
    logic [7:0]  buff_din0;
    logic [7:0]  buff_din1;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [1:0]  buff_wr;
    logic [8:0]  buff_addr;
    logic [7:0]  buff_dout;
    logic        sd_rd;
    logic        sd_wr;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    // master: the arbiter itself
    modport master (
        input  req_rd, req_wr, lba0, lba1, buff_din0, buff_din1,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output grant, done, err, buff_wr, buff_addr, buff_dout,
        output sd_rd, sd_wr, sd_lba, sd_buff_din
    );

    // slave: requesters plus user_io
    modport slave (
        output req_rd, req_wr, lba0, lba1, buff_din0, buff_din1,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  grant, done, err, buff_wr, buff_addr, buff_dout,
        input  sd_rd, sd_wr, sd_lba, sd_buff_din
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin sharing of the user_io SD sector port between two requesters.
// Define SD_ARB_TIMEOUT_EN to abort transfers that exceed TIMEOUT_CYCLES.
module sd_req_arbiter #(
    parameter int              TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd16777215
) (
    input logic               clk_sys,
    input logic               reset,
    sd_req_arbiter_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

    if (TO_W < 1 || TIMEOUT_CYCLES == '0) begin : g_cfg_check
        $error("sd_req_arbiter: TIMEOUT_CYCLES must be nonzero");
    end

    state_t      state;
    logic        ptr;
    logic [1:0]  grant_q;
    logic [1:0]  done_q;
    logic        sd_rd_q;
    logic        sd_wr_q;
    logic [31:0] sd_lba_q;

    logic [1:0]  pending;
    logic        win1;
    logic        win_rd;

    assign pending = bus.req_rd | bus.req_wr;
    // requester 1 wins if it is alone or the pointer favours it
    assign win1    = pending[1] & (~pending[0] | ptr);
    assign win_rd  = win1 ? bus.req_rd[1] : bus.req_rd[0];

`ifdef SD_ARB_TIMEOUT_EN
    logic [1:0]      err_q;
    logic [TO_W-1:0] to_cnt;
    logic            ack_fall;

    // a finishing transfer beats a coincident expiry
    assign ack_fall = (state == S_XFER) && !bus.sd_ack;
    assign bus.err  = err_q;
`else
    assign bus.err  = 2'b00;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= 1'b0;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            sd_lba_q <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            err_q    <= 2'b00;
            to_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (|pending) begin
                    grant_q  <= win1 ? 2'b10 : 2'b01;
                    sd_lba_q <= win1 ? bus.lba1 : bus.lba0;
                    sd_rd_q  <= win_rd;
                    sd_wr_q  <= ~win_rd;
                    state    <= S_ISSUE;
                end
                S_ISSUE: if (bus.sd_ack) begin
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                    state   <= S_XFER;
                end
                S_XFER: if (!bus.sd_ack) begin
                    done_q <= grant_q;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 2'b00;
                    grant_q <= 2'b00;
                    ptr     <= grant_q[0];
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
`ifdef SD_ARB_TIMEOUT_EN
            if (state == S_IDLE) begin
                to_cnt <= '0;
            end else if (state == S_ISSUE || state == S_XFER) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TIMEOUT_CYCLES - TO_W'(1) && !ack_fall) begin
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                    err_q   <= grant_q;
                    state   <= S_DONE;
                end
            end
            if (state == S_DONE) err_q <= 2'b00;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.sd_rd       = sd_rd_q;
    assign bus.sd_wr       = sd_wr_q;
    assign bus.sd_lba      = sd_lba_q;
    assign bus.buff_wr     = grant_q & {2{bus.sd_buff_wr}};
    assign bus.sd_buff_din = grant_q[1] ? bus.buff_din1 : bus.buff_din0;
    assign bus.buff_addr   = bus.sd_buff_addr;
    assign bus.buff_dout   = bus.sd_buff_dout;
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter: stimulus queues expectations, a negedge
// monitor compares them whenever the arbiter shows an issue, pulse or strobe.
module tb_sd_req_arbiter;
    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter_if bus();

    sd_req_arbiter #(.TO_W(24), .TIMEOUT_CYCLES(24'd100)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic [1:0]  grant;
        logic [1:0]  done;
        logic [1:0]  err;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
    } snap_t;
    typedef struct packed {logic [1:0] grant; logic rd; logic wr; logic [31:0] lba;} iss_t;
    typedef struct packed {logic [1:0] done; logic [1:0] err;} cmp_t;
    typedef struct packed {logic [1:0] wr; logic [7:0] din; logic [8:0] addr; logic [7:0] dout;} route_t;

    snap_t  snap_q[$];
    iss_t   iss_q[$];
    cmp_t   cmp_q[$];
    route_t route_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     end_req = 1'b0;
    logic   prev_iss = 1'b0;
    logic [3:0] prev_de = 4'h0;

    always @(negedge clk_sys) begin : monitor
        snap_t  s;
        iss_t   ie;
        cmp_t   ce;
        route_t re;
        logic   cur_iss;
        cur_iss = bus.sd_rd | bus.sd_wr;
        if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.err, bus.sd_rd, bus.sd_wr, bus.sd_lba} !==
                {s.grant, s.done, s.err, s.rd, s.wr, s.lba}) begin
                errors++;
                $display("FAIL %s: got grant=%b done=%b err=%b rd=%b wr=%b lba=%h, want grant=%b done=%b err=%b rd=%b wr=%b lba=%h",
                         s.name, bus.grant, bus.done, bus.err, bus.sd_rd, bus.sd_wr, bus.sd_lba,
                         s.grant, s.done, s.err, s.rd, s.wr, s.lba);
            end
        end
        if (cur_iss === 1'b1 && prev_iss !== 1'b1) begin
            checks++;
            if (iss_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got grant=%b lba=%h, want no issue", bus.grant, bus.sd_lba);
            end else begin
                ie = iss_q.pop_front();
                if ({bus.grant, bus.sd_rd, bus.sd_wr, bus.sd_lba} !== ie) begin
                    errors++;
                    $display("FAIL issue: got grant=%b rd=%b wr=%b lba=%h, want grant=%b rd=%b wr=%b lba=%h",
                             bus.grant, bus.sd_rd, bus.sd_wr, bus.sd_lba, ie.grant, ie.rd, ie.wr, ie.lba);
                end
            end
        end
        if ((bus.done | bus.err) != 2'b00) begin
            checks++;
            if (cmp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got done=%b err=%b, want none", bus.done, bus.err);
            end else begin
                ce = cmp_q.pop_front();
                if ({bus.done, bus.err} !== ce) begin
                    errors++;
                    $display("FAIL pulse: got done=%b err=%b, want done=%b err=%b", bus.done, bus.err, ce.done, ce.err);
                end
            end
            checks++;
            if (prev_de !== 4'h0) begin
                errors++;
                $display("FAIL pulse_len: got previous done/err=%b, want 0000", prev_de);
            end
        end
        if (bus.sd_buff_wr === 1'b1) begin
            checks++;
            if (route_q.size() == 0) begin
                errors++;
                $display("FAIL route_unexpected: got buff_wr=%b, want no strobe", bus.buff_wr);
            end else begin
                re = route_q.pop_front();
                if ({bus.buff_wr, bus.sd_buff_din, bus.buff_addr, bus.buff_dout} !== re) begin
                    errors++;
                    $display("FAIL route: got buff_wr=%b din=%h addr=%h dout=%h, want buff_wr=%b din=%h addr=%h dout=%h",
                             bus.buff_wr, bus.sd_buff_din, bus.buff_addr, bus.buff_dout, re.wr, re.din, re.addr, re.dout);
                end
            end
        end
        if (end_req) begin
            checks++;
            if (snap_q.size() + iss_q.size() + cmp_q.size() + route_q.size() != 0) begin
                errors++;
                $display("FAIL drained: got %0d/%0d/%0d/%0d unseen snap/issue/pulse/route events, want 0",
                         snap_q.size(), iss_q.size(), cmp_q.size(), route_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        prev_iss <= cur_iss;
        prev_de  <= {bus.done, bus.err};
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic snap(input string nm, input logic [1:0] g, input logic [1:0] d, input logic [1:0] e,
                        input logic rd, input logic wr, input logic [31:0] lba);
        snap_t s;
        s.name = nm; s.grant = g; s.done = d; s.err = e; s.rd = rd; s.wr = wr; s.lba = lba;
        snap_q.push_back(s);
    endtask

    task automatic wait_issue();
        int n = 0;
        while ((bus.sd_rd | bus.sd_wr) !== 1'b1) begin
            if (n == 20) begin
                $display("FAIL wait_issue: got no sd_rd/sd_wr in 20 cycles, want issue");
                $fatal(1, "wait_issue");
            end
            tick();
            n++;
        end
    endtask

    // Host side of one transfer; entered in the ISSUE cycle, returns in the DONE cycle.
    task automatic serve(input int nstrobe, input logic [1:0] who);
        route_t r;
        int n = 0;
        bus.sd_ack = 1'b1;
        for (int k = 0; k < nstrobe; k++) begin
            tick();
            bus.sd_buff_wr   = 1'b1;
            bus.sd_buff_addr = 9'(k);
            bus.sd_buff_dout = 8'(k * 7 + 3);
            r.wr = who; r.din = who[1] ? bus.buff_din1 : bus.buff_din0;
            r.addr = 9'(k); r.dout = 8'(k * 7 + 3);
            route_q.push_back(r);
        end
        tick();
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
        tick();
        while ((bus.done | bus.err) === 2'b00) begin
            if (n == 8) begin
                $display("FAIL serve_done: got no done/err pulse, want pulse to %b", who);
                $fatal(1, "serve");
            end
            tick();
            n++;
        end
        bus.req_rd = bus.req_rd & ~who;
        bus.req_wr = bus.req_wr & ~who;
    endtask

    initial begin : stim
        reset = 1'b1;
        bus.req_rd = 2'b00; bus.req_wr = 2'b00;
        bus.lba0 = '0; bus.lba1 = '0; bus.buff_din0 = 8'h00; bus.buff_din1 = 8'h00;
        bus.sd_ack = 1'b0; bus.sd_buff_addr = '0; bus.sd_buff_dout = '0; bus.sd_buff_wr = 1'b0;
        repeat (3) tick();
        snap("reset_state", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b0;

        // single read
        tick();
        bus.lba0 = 32'h0000_1234; bus.req_rd = 2'b01;
        snap("idle_before_issue", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        iss_q.push_back({2'b01, 1'b1, 1'b0, 32'h0000_1234});
        cmp_q.push_back({2'b01, 2'b00});
        tick();
        snap("rd_latency", 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_1234);
        bus.sd_ack = 1'b1;
        tick();
        snap("rd_drop_on_ack", 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_1234);
        bus.sd_ack = 1'b0;
        tick();
        snap("done_pulse", 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0000_1234);
        bus.req_rd = 2'b00;
        tick();
        snap("grant_clear", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_1234);

        // contention after reset: 0, 1, 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.lba0 = 32'h0000_00A0; bus.lba1 = 32'h0000_00B1; bus.req_rd = 2'b11;
        iss_q.push_back({2'b01, 1'b1, 1'b0, 32'h0000_00A0});
        iss_q.push_back({2'b10, 1'b1, 1'b0, 32'h0000_00B1});
        iss_q.push_back({2'b01, 1'b1, 1'b0, 32'h0000_00A2});
        cmp_q.push_back({2'b01, 2'b00});
        cmp_q.push_back({2'b10, 2'b00});
        cmp_q.push_back({2'b01, 2'b00});
        tick();
        snap("rr_first", 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_00A0);
        serve(0, 2'b01);
        tick();
        snap("rr_gap1", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_00A0);
        bus.lba0 = 32'h0000_00A2; bus.req_rd[0] = 1'b1;
        tick();
        snap("rr_second", 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_00B1);
        serve(0, 2'b10);
        tick();
        snap("rr_gap2", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_00B1);
        tick();
        snap("rr_third", 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_00A2);
        serve(0, 2'b01);
        tick();

        // full-sector write from requester 1, buffer routing
        bus.buff_din0 = 8'h5A; bus.buff_din1 = 8'hA5;
        bus.lba1 = 32'h0000_0777; bus.req_wr = 2'b10;
        iss_q.push_back({2'b10, 1'b0, 1'b1, 32'h0000_0777});
        cmp_q.push_back({2'b10, 2'b00});
        tick();
        wait_issue();
        serve(512, 2'b10);
        tick();

        // rd+wr collision with ack already high on entering ISSUE
        bus.sd_ack = 1'b1; bus.lba0 = 32'h0000_0042;
        bus.req_rd = 2'b01; bus.req_wr = 2'b01;
        iss_q.push_back({2'b01, 1'b1, 1'b0, 32'h0000_0042});
        cmp_q.push_back({2'b01, 2'b00});
        tick();
        snap("collision_issue", 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0000_0042);
        tick();
        snap("early_ack_xfer", 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_0042);
        serve(4, 2'b01);
        tick();

        // reset in the middle of a transfer, then a normal request
        bus.lba1 = 32'h0000_0099; bus.req_rd = 2'b10;
        iss_q.push_back({2'b10, 1'b1, 1'b0, 32'h0000_0099});
        tick();
        bus.sd_ack = 1'b1;
        tick();
        snap("xfer_before_reset", 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_0099);
        reset = 1'b1;
        tick();
        snap("reset_abort", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        bus.req_rd = 2'b00; bus.sd_ack = 1'b0; reset = 1'b0;
        tick();
        bus.lba0 = 32'h0000_0055; bus.req_rd = 2'b01;
        iss_q.push_back({2'b01, 1'b1, 1'b0, 32'h0000_0055});
        cmp_q.push_back({2'b01, 2'b00});
        tick();
        serve(2, 2'b01);
        tick();

        // a transfer that never gets acked
        bus.lba1 = 32'h0000_0100; bus.req_wr = 2'b10;
        iss_q.push_back({2'b10, 1'b0, 1'b1, 32'h0000_0100});
        tick();
        repeat (99) tick();
        snap("to_pre_expiry", 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0000_0100);
`ifdef SD_ARB_TIMEOUT_EN
        cmp_q.push_back({2'b00, 2'b10});
        tick();
        snap("to_expiry", 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0000_0100);
        bus.req_wr = 2'b00;
        tick();
        snap("to_after", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_0100);
`else
        cmp_q.push_back({2'b10, 2'b00});
        repeat (200) tick();
        snap("no_timeout_wait", 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0000_0100);
        serve(0, 2'b10);
        tick();
`endif
        repeat (3) tick();
        end_req = 1'b1;
    end
endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares the single user_io SD block interface (sd_rd/sd_wr/sd_lba/sd_ack plus sector buffer bus) between two block-device requesters on clk_sys.
- Requester 0 is the emsx SD/MMC emulation (sd_card); requester 1 is a second image/drive channel.
- Serialises one 512-byte sector transfer at a time, with round-robin fairness.
- Steers buffer strobes and data to and from the granted requester only.

Parameters:
- TIMEOUT_CYCLES, 24'd16777215: cycles allowed in ISSUE+XFER before abort (only with the optional feature).
- TO_W, 24: width of the timeout counter.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- req_rd  in  2  per-requester read request, level, held until done
- req_wr  in  2  per-requester write request, level, held until done
- lba0  in  32  requester 0 sector address, stable while request is high
- lba1  in  32  requester 1 sector address
- buff_din0  in  8  requester 0 write data for the current buff_addr
- buff_din1  in  8  requester 1 write data
- grant  out  2  one-hot owner of the host interface; 00 when idle
- done  out  2  one-cycle completion pulse to the owner
- err  out  2  one-cycle abort pulse to the owner (timeout)
- buff_wr  out  2  sd_buff_wr routed to the owner only
- buff_addr  out  9  sd_buff_addr passthrough
- buff_dout  out  8  sd_buff_dout passthrough
- sd_rd  out  1  to user_io
- sd_wr  out  1  to user_io
- sd_lba  out  32  to user_io
- sd_ack  in  1  from user_io
- sd_buff_addr  in  9  from user_io
- sd_buff_dout  in  8  from user_io
- sd_buff_wr  in  1  from user_io
- sd_buff_din  out  8  to user_io, muxed from buff_din0/1

Behaviour:
- Reset values:
  - State IDLE; priority pointer 0.
  - grant, done, err, sd_rd, sd_wr all 0; sd_lba 0; timeout counter 0.
  - Reset mid-transfer aborts immediately; no done pulse is issued.
- IDLE:
  - Requester i is pending if req_rd[i]|req_wr[i].
  - If both are pending, the requester at the priority pointer wins. If one is pending, it wins.
  - On a win: latch op (read if req_rd set; read wins if both rd and wr are set); latch sd_lba from lba0/lba1; set grant one-hot.
  - Go to ISSUE. Transition takes one cycle from request to the sd_rd/sd_wr assertion.
- ISSUE:
  - Hold sd_rd or sd_wr high and sd_lba stable.
  - On sampled sd_ack=1: clear sd_rd/sd_wr in the same edge, go to XFER.
- XFER:
  - Wait for sd_ack=0, then go to DONE.
  - sd_lba stays latched.
- DONE:
  - done[owner]=1 for exactly one cycle; grant cleared at the end of the cycle.
  - Priority pointer set to the other requester. Go to IDLE.
  - The requester must drop req on the edge where it sees done. The arbiter does not re-evaluate the same requester until the following IDLE cycle.
- Routing (combinational, valid only while grant != 0):
  - buff_wr = grant & {2{sd_buff_wr}}.
  - sd_buff_din = grant[1] ? buff_din1 : buff_din0.
  - buff_addr and buff_dout are direct passthrough.
  - When grant==00, buff_wr=00.
- Boundary rules:
  - Requests that arrive while busy stay pending; they are never lost or reordered beyond round-robin.
  - sd_ack already high on entering ISSUE: treated as ack; XFER then waits for the fall.
  - A req drop by the owner mid-transfer is ignored; the transfer completes and done still pulses.
  - Back-to-back requests from both requesters alternate 0,1,0,1.

Optional Feature:
- Macro SD_ARB_TIMEOUT_EN.
- With the macro:
  - Counter clears on IDLE->ISSUE and increments each cycle in ISSUE/XFER.
  - At TIMEOUT_CYCLES: drop sd_rd/sd_wr, pulse err[owner] (not done) for one cycle, advance the pointer, return to IDLE.
  - An sd_ack fall on the same cycle as expiry counts as done; done wins.
- Without the macro: err is tied 00, there is no counter, and the arbiter waits indefinitely.

Test Plan:
- Single read: req_rd=01, lba0=0x00001234 → sd_rd=1 and sd_lba=0x00001234 one cycle later. When sd_ack rises: sd_rd=0. After the ack fall: done=01 for 1 cycle, then grant=00.
- Contention: after reset, req_rd=11 → requester 0 served first. Then requester 1 with sd_lba=lba1. Then requester 0 again; order 0,1,0 with no idle gaps beyond one cycle.
- Buffer routing: requester 1 write, buff_din1=0xA5, buff_din0=0x5A, 512 sd_buff_wr strobes → sd_buff_din=0xA5 and buff_wr=10 on every strobe; buff_wr[0] stays 0.
- Read/write collision: req_rd[0]=1 and req_wr[0]=1 → sd_rd asserted, sd_wr stays 0.
- Reset mid-XFER: assert reset while sd_ack=1 → next cycle grant=00, sd_rd=sd_wr=0, done=00. A subsequent request is served normally.
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100): req_wr=10, sd_ack never rises → err=10 exactly 100 cycles after ISSUE entry, sd_wr=0, done stays 00.
